ram_port_arbiter: RTL and testbench

- Two-requester arbiter in front of a single-port synchronous RAM (`we`, `addr`, `din`, `dout`).
- Arbitrates per cycle with round-robin priority and supports locked bursts.
- Drives the RAM port and routes the read data back to the requester that issued the read.
- Sits between the client blocks and the RAM; the RAM's ports are connected unchanged.

---
 rtl/ram_port_arbiter_if.sv | 25 ++
 rtl/ram_port_arbiter.sv | 121 ++++++++++++
 tb/tb_ram_port_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// Requester-side handshake bundle for ram_port_arbiter.
// master = client block, slave = arbiter.
interface ram_port_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  valid;
  logic                  we;
  logic                  lock;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] din;
  logic                  ready;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output valid, we, lock, addr, din,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, we, lock, addr, din,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter with locked bursts for a 1-port sync RAM.
// Define ARB_FIXED_PRIORITY_EN to make requester 0 always win in IDLE.
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_port_arbiter_if.slave     i_req0,
  ram_port_arbiter_if.slave     i_req1,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_din,
  input  logic [DATA_WIDTH-1:0] i_ram_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_rd_pend;
  logic   r_rd_id;
  logic   w_gnt0;
  logic   w_gnt1;
  logic   w_prio;
  logic   w_rv0;
  logic   w_rv1;

`ifdef ARB_FIXED_PRIORITY_EN
  assign w_prio = 1'b0;
`else
  logic r_prio;

  // points at the requester that did not move last
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio <= 1'b0;
    end else if (w_gnt0 || w_gnt1) begin
      r_prio <= w_gnt0;
    end
  end

  assign w_prio = r_prio;
`endif

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    w_next = r_state;
    if (!rst) begin
      unique case (r_state)
        IDLE: begin
          if (i_req0.valid && i_req1.valid) begin
            w_gnt0 = !w_prio;
            w_gnt1 = w_prio;
          end else begin
            w_gnt0 = i_req0.valid;
            w_gnt1 = i_req1.valid;
          end
        end
        LOCK0:   w_gnt0 = i_req0.valid;
        LOCK1:   w_gnt1 = i_req1.valid;
        default: w_next = IDLE;
      endcase
      if (w_gnt0) begin
        w_next = i_req0.lock ? LOCK0 : IDLE;
      end else if (w_gnt1) begin
        w_next = i_req1.lock ? LOCK1 : IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rd_pend <= 1'b0;
      r_rd_id   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_rd_pend <= (w_gnt0 && !i_req0.we)
                || (w_gnt1 && !i_req1.we);
      if (w_gnt0 || w_gnt1) begin
        r_rd_id <= w_gnt1;
      end
    end
  end

  always_comb begin
    o_ram_we   = 1'b0;
    o_ram_addr = '0;
    o_ram_din  = '0;
    unique case (1'b1)
      w_gnt0: begin
        o_ram_we   = i_req0.we;
        o_ram_addr = i_req0.addr;
        o_ram_din  = i_req0.din;
      end
      w_gnt1: begin
        o_ram_we   = i_req1.we;
        o_ram_addr = i_req1.addr;
        o_ram_din  = i_req1.din;
      end
      default: ;
    endcase
  end

  assign w_rv0 = r_rd_pend && !r_rd_id;
  assign w_rv1 = r_rd_pend && r_rd_id;

  assign i_req0.ready  = w_gnt0;
  assign i_req1.ready  = w_gnt1;
  assign i_req0.rvalid = w_rv0;
  assign i_req1.rvalid = w_rv1;
  assign i_req0.rdata  = w_rv0 ? i_ram_dout : '0;
  assign i_req1.rdata  = w_rv1 ? i_ram_dout : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter with a behavioural RAM
// and a per-requester read-data scoreboard.
module tb_ram_port_arbiter;

  logic       clk;
  logic       rst;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;

  logic [7:0] mem    [16];
  logic [7:0] shadow [16];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  int n_chk;
  int n_err;

  ram_port_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) m0 ();
  ram_port_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) m1 ();

  ram_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_req0     (m0),
    .i_req1     (m1),
    .o_ram_we   (ram_we),
    .o_ram_addr (ram_addr),
    .o_ram_din  (ram_din),
    .i_ram_dout (ram_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int n, input logic v, input logic we,
                         input logic lk, input logic [3:0] a,
                         input logic [7:0] d);
    if (n == 0) begin
      m0.valid = v; m0.we = we; m0.lock = lk;
      m0.addr = a; m0.din = d;
    end else begin
      m1.valid = v; m1.we = we; m1.lock = lk;
      m1.addr = a; m1.din = d;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Responses are due exactly one cycle after acceptance.
  always @(negedge clk) begin
    check("rv0", {31'd0, m0.rvalid}, {31'd0, q0.size() != 0});
    if (m0.rvalid && q0.size() != 0)
      check("rdata0", {24'd0, m0.rdata}, {24'd0, q0.pop_front()});
    check("rv1", {31'd0, m1.rvalid}, {31'd0, q1.size() != 0});
    if (m1.rvalid && q1.size() != 0)
      check("rdata1", {24'd0, m1.rdata}, {24'd0, q1.pop_front()});
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (m0.valid && m0.ready) begin
        if (m0.we) shadow[m0.addr] = m0.din;
        else q0.push_back(shadow[m0.addr]);
      end
      if (m1.valid && m1.ready) begin
        if (m1.we) shadow[m1.addr] = m1.din;
        else q1.push_back(shadow[m1.addr]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic e0;
    n_chk = 0;
    n_err = 0;
    for (int i = 0; i < 16; i++) begin
      mem[i] = 8'h00;
      shadow[i] = 8'h00;
    end
    ram_dout = 8'h00;
    rst = 1'b1;
    set_req(0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    set_req(1, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);

    repeat (2) begin
      @(negedge clk);
      check("rst_rdy0", {31'd0, m0.ready}, 32'd0);
      check("rst_rdy1", {31'd0, m1.ready}, 32'd0);
      check("rst_we", {31'd0, ram_we}, 32'd0);
      tick();
    end
    rst = 1'b0;
    @(negedge clk);
    check("first_rdy0", {31'd0, m0.ready}, 32'd1);
    check("first_rdy1", {31'd0, m1.ready}, 32'd0);
    tick();

    set_req(0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    set_req(1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    @(negedge clk);
    check("idle_we", {31'd0, ram_we}, 32'd0);
    check("idle_addr", {28'd0, ram_addr}, 32'd0);
    check("idle_din", {24'd0, ram_din}, 32'd0);
    tick();

    set_req(0, 1'b1, 1'b1, 1'b0, 4'd3, 8'hA5);
    @(negedge clk);
    check("wr_rdy0", {31'd0, m0.ready}, 32'd1);
    check("wr_we", {31'd0, ram_we}, 32'd1);
    check("wr_addr", {28'd0, ram_addr}, 32'd3);
    check("wr_din", {24'd0, ram_din}, 32'hA5);
    tick();
    set_req(0, 1'b1, 1'b0, 1'b0, 4'd3, 8'h00);
    @(negedge clk);
    check("rd_rdy0", {31'd0, m0.ready}, 32'd1);
    tick();
    set_req(0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    @(negedge clk);
    check("rd_rv0", {31'd0, m0.rvalid}, 32'd1);
    check("rd_data0", {24'd0, m0.rdata}, 32'hA5);
    check("rd_rv1", {31'd0, m1.rvalid}, 32'd0);
    tick();

    set_req(0, 1'b1, 1'b1, 1'b0, 4'd1, 8'h11);
    tick();
    set_req(0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    set_req(1, 1'b1, 1'b1, 1'b0, 4'd2, 8'h22);
    tick();

    set_req(0, 1'b1, 1'b0, 1'b0, 4'd1, 8'h00);
    set_req(1, 1'b1, 1'b0, 1'b0, 4'd2, 8'h00);
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_FIXED_PRIORITY_EN
      e0 = 1'b1;
`else
      e0 = (k % 2 == 0);
`endif
      @(negedge clk);
      check($sformatf("arb%0d_rdy0", k), {31'd0, m0.ready}, {31'd0, e0});
      check($sformatf("arb%0d_rdy1", k), {31'd0, m1.ready}, {31'd0, !e0});
      tick();
    end
    set_req(0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    set_req(1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    tick();

    for (int k = 0; k < 3; k++) begin
      set_req(1, 1'b1, 1'b1, k < 2, 4'(4 + k), 8'(8'h40 + k));
      set_req(0, k > 0, 1'b0, 1'b0, 4'd1, 8'h00);
      @(negedge clk);
      check($sformatf("burst%0d_rdy1", k), {31'd0, m1.ready}, 32'd1);
      check($sformatf("burst%0d_rdy0", k), {31'd0, m0.ready}, 32'd0);
      tick();
    end
    set_req(1, 1'b1, 1'b1, 1'b0, 4'd7, 8'h77);
    @(negedge clk);
    check("post_burst_rdy0", {31'd0, m0.ready}, 32'd1);
    check("post_burst_rdy1", {31'd0, m1.ready}, 32'd0);
    tick();

    set_req(1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    set_req(0, 1'b1, 1'b0, 1'b1, 4'd4, 8'h00);
    tick();
    set_req(0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    set_req(1, 1'b1, 1'b0, 1'b0, 4'd5, 8'h00);
    @(negedge clk);
    check("hold_rdy1", {31'd0, m1.ready}, 32'd0);
    tick();
    set_req(0, 1'b1, 1'b0, 1'b0, 4'd6, 8'h00);
    @(negedge clk);
    check("rel_rdy0", {31'd0, m0.ready}, 32'd1);
    check("rel_rdy1", {31'd0, m1.ready}, 32'd0);
    tick();
    set_req(0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    @(negedge clk);
    check("after_rel_rdy1", {31'd0, m1.ready}, 32'd1);
    tick();

    set_req(1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    set_req(0, 1'b1, 1'b0, 1'b1, 4'd5, 8'h00);
    @(negedge clk);
    check("mid_rdy0", {31'd0, m0.ready}, 32'd1);
    tick();
    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    set_req(1, 1'b1, 1'b0, 1'b0, 4'd6, 8'h00);
    @(negedge clk);
    check("mid_rst_rdy1", {31'd0, m1.ready}, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rv0", {31'd0, m0.rvalid}, 32'd0);
    check("mid_idle_rdy1", {31'd0, m1.ready}, 32'd1);
    tick();

    set_req(1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    tick();
    tick();
    @(negedge clk);
    check("q_drain", q0.size() + q1.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
